// File: rtl/apb_master.sv
// APB requester: one command in, one APB transfer out, one response back.
// Latency: accept -> rsp_valid_o is 3 cycles minimum (SETUP, ACCESS, RESP); illegal commands respond after 1 cycle.
// Backpressure: cmd_ready_o only in IDLE; a response is held in RESP until rsp_ready_i, so at most one transfer is outstanding.
module apb_master #(
    parameter logic [11:0] ADDR_MIN       = 12'h000,
    parameter logic [11:0] ADDR_MAX       = 12'h010,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        pclk,
    input  logic        preset,
    // command channel
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [11:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    input  logic [3:0]  cmd_strb_i,
    // response channel
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_slverr_o,
    output logic        rsp_timeout_o,
    // APB requester side
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [11:0] paddr,
    output logic [31:0] pwdata,
    output logic [3:0]  pstrb,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    // last wait cycle index before the counter saturates
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [11:0]      ADDR_SPAN = ADDR_MAX - ADDR_MIN;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    // one-entry command register
    logic             r_write;
    logic [11:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_strb;

    // response register
    logic [31:0]      r_rdata;
    logic             r_slverr;
    logic             r_timeout;

    // registered control outputs
    logic             r_cmd_rdy;
    logic             r_psel;
    logic             r_penable;
    logic             r_rsp_vld;

    logic             w_cmd_legal;
    logic             w_apb_on;
    logic             w_wr_on;

    // Range check as one unsigned compare: addresses below ADDR_MIN wrap to large values.
    assign w_cmd_legal = ((cmd_addr_i - ADDR_MIN) <= ADDR_SPAN) && (cmd_addr_i[1:0] == 2'b00);

    // Control state machine; all outputs registered alongside the state.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_strb    <= '0;
            r_rdata   <= '0;
            r_slverr  <= 1'b0;
            r_timeout <= 1'b0;
            r_cmd_rdy <= 1'b1;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_rsp_vld <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        r_write   <= cmd_write_i;
                        r_addr    <= cmd_addr_i;
                        r_wdata   <= cmd_wdata_i;
                        r_strb    <= cmd_strb_i;
                        r_cmd_rdy <= 1'b0;
                        if (w_cmd_legal) begin
                            r_state <= S_SETUP;
                            r_psel  <= 1'b1;
                        end else begin
                            // rejected without touching the bus
                            r_state   <= S_RESP;
                            r_rsp_vld <= 1'b1;
                            r_rdata   <= '0;
                            r_slverr  <= 1'b1;
                            r_timeout <= 1'b0;
                        end
                    end
                end
                S_SETUP: begin
                    r_state   <= S_ACCESS;
                    r_penable <= 1'b1;
                    r_cnt     <= '0;
                end
                S_ACCESS: begin
                    if (pready) begin
                        // completion wins over a simultaneous timeout
                        r_state   <= S_RESP;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_rsp_vld <= 1'b1;
                        r_rdata   <= r_write ? 32'h0 : prdata;
                        r_slverr  <= pslverr;
                        r_timeout <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_cnt     <= CNT_SAT;
                        r_state   <= S_RESP;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_rsp_vld <= 1'b1;
                        r_rdata   <= '0;
                        r_slverr  <= 1'b1;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_state   <= S_IDLE;
                        r_rsp_vld <= 1'b0;
                        r_cmd_rdy <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Reset forces every output low immediately, independent of the registered state.
    assign w_apb_on      = r_psel & ~preset;
    assign w_wr_on       = w_apb_on & r_write;

    assign cmd_ready_o   = r_cmd_rdy & ~preset;
    assign psel          = w_apb_on;
    assign penable       = r_penable & ~preset;
    assign pwrite        = w_wr_on;
    assign paddr         = w_apb_on ? r_addr : 12'h0;
    assign pwdata        = w_wr_on ? r_wdata : 32'h0;
    assign pstrb         = w_wr_on ? r_strb : 4'h0;

    assign rsp_valid_o   = r_rsp_vld & ~preset;
    assign rsp_rdata_o   = preset ? 32'h0 : r_rdata;
    assign rsp_slverr_o  = r_slverr & ~preset;
    assign rsp_timeout_o = r_timeout & ~preset;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: transaction-level reference model checked every cycle, directed scenarios, then random traffic.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
// Responses are consumed according to the random or directed rsp_ready_i pattern.
module tb_apb_master;

    localparam logic [11:0] A_MIN = 12'h000;
    localparam logic [11:0] A_MAX = 12'h010;
    localparam int          TO    = 16;

    logic        pclk = 1'b0;
    logic        preset;
    logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
    logic [11:0] cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic [3:0]  cmd_strb_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_slverr_o, rsp_timeout_o;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready, pslverr;

    always #5 pclk = ~pclk;

    apb_master #(
        .ADDR_MIN(A_MIN),
        .ADDR_MAX(A_MAX),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_slverr_o(rsp_slverr_o), .rsp_timeout_o(rsp_timeout_o),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    // m_age counts cycles since acceptance: 1 = setup cycle, k >= 2 = access cycle number k-1.
    logic        m_active = 1'b0;
    logic        m_resp   = 1'b0;
    logic        m_w      = 1'b0;
    logic [11:0] m_addr   = '0;
    logic [31:0] m_wd     = '0;
    logic [3:0]  m_st     = '0;
    logic [31:0] m_rd     = '0;
    logic        m_err    = 1'b0;
    logic        m_to     = 1'b0;
    int          m_age    = 0;
    int          m_last_acc = -1;

    function automatic bit legal_addr(input logic [11:0] a);
        int v;
        v = int'(a);
        return (v >= int'(A_MIN)) && (v <= int'(A_MAX)) && (v % 4 == 0);
    endfunction

    always @(posedge pclk) begin
        if (preset) begin
            m_active = 1'b0;
            m_resp   = 1'b0;
        end else if (m_resp) begin
            if (rsp_ready_i) m_resp = 1'b0;
        end else if (m_active) begin
            if (m_age >= 2) begin
                if (pready) begin
                    m_rd = m_w ? 32'h0 : prdata;
                    m_err = pslverr;
                    m_to = 1'b0;
                    m_active = 1'b0;
                    m_resp = 1'b1;
                    m_last_acc = m_age - 1;
                end else if (m_age - 1 == TO) begin
                    m_rd = 32'h0;
                    m_err = 1'b1;
                    m_to = 1'b1;
                    m_active = 1'b0;
                    m_resp = 1'b1;
                    m_last_acc = m_age - 1;
                end
            end
            m_age++;
        end else if (cmd_valid_i) begin
            m_w = cmd_write_i;
            m_addr = cmd_addr_i;
            m_wd = cmd_wdata_i;
            m_st = cmd_strb_i;
            if (legal_addr(cmd_addr_i)) begin
                m_active = 1'b1;
                m_age = 1;
            end else begin
                m_resp = 1'b1;
                m_rd = 32'h0;
                m_err = 1'b1;
                m_to = 1'b0;
                m_last_acc = 0;
            end
        end
    end

    // ---------------- observed activity, for directed literal checks ----------------
    int   obs_psel = 0, obs_pen = 0, obs_rsp = 0, obs_lat = 0;
    logic [3:0]  obs_strb_or = '0;
    logic [31:0] obs_wd_or   = '0;
    bit   obs_cnt_on = 1'b0;

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge pclk) begin
        logic        e_on;
        logic        e_wr;
        e_on = m_active && !preset;
        e_wr = e_on && m_w;
        chk("cmd_ready_o", cmd_ready_o, !preset && !m_active && !m_resp);
        chk("psel",        psel,        e_on);
        chk("penable",     penable,     e_on && (m_age >= 2));
        chk("pwrite",      pwrite,      e_wr);
        chk("paddr",       paddr,       e_on ? m_addr : 12'h0);
        chk("pwdata",      pwdata,      e_wr ? m_wd : 32'h0);
        chk("pstrb",       pstrb,       e_wr ? m_st : 4'h0);
        chk("rsp_valid_o", rsp_valid_o, m_resp && !preset);
        if (m_resp && !preset) begin
            chk("rsp_rdata_o",   rsp_rdata_o,   m_rd);
            chk("rsp_slverr_o",  rsp_slverr_o,  m_err);
            chk("rsp_timeout_o", rsp_timeout_o, m_to);
        end
        if (preset) begin
            chk("rst_rdata",   rsp_rdata_o,   32'h0);
            chk("rst_slverr",  rsp_slverr_o,  1'b0);
            chk("rst_timeout", rsp_timeout_o, 1'b0);
        end
        obs_psel    += int'(psel);
        obs_pen     += int'(penable);
        obs_rsp     += int'(rsp_valid_o);
        obs_strb_or |= pstrb & {4{psel}};
        obs_wd_or   |= pwdata & {32{psel}};
        if (obs_cnt_on) begin
            obs_lat++;
            if (rsp_valid_o) obs_cnt_on = 1'b0;
        end
        if (cmd_valid_i && cmd_ready_o) begin
            obs_lat = 0;
            obs_cnt_on = 1'b1;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic clr_obs();
        obs_psel = 0;
        obs_pen = 0;
        obs_rsp = 0;
        obs_strb_or = '0;
        obs_wd_or = '0;
    endtask

    task automatic send(input logic w, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        cmd_valid_i = 1'b1;
        cmd_write_i = w;
        cmd_addr_i  = a;
        cmd_wdata_i = d;
        cmd_strb_i  = s;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    // Ends half a cycle after rsp_valid_o rises so the falling-edge observers are current.
    task automatic wait_rsp(input int lim);
        int n;
        n = 0;
        while (!rsp_valid_o && n < lim) begin
            tick();
            n++;
        end
        chk("rsp_arrives", rsp_valid_o, 1'b1);
        @(negedge pclk);
        #1;
    endtask

    task automatic consume();
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int thr;
        preset = 1'b1;
        cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0; cmd_strb_i = '0;
        rsp_ready_i = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;

        // reset state, with a command and response-ready offered during reset
        cmd_valid_i = 1'b1;
        rsp_ready_i = 1'b1;
        repeat (3) tick();
        chk("rst_cmd_ready", cmd_ready_o, 1'b0);
        chk("rst_psel",      psel,        1'b0);
        chk("rst_rsp_valid", rsp_valid_o, 1'b0);
        cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        preset = 1'b0;
        tick();
        chk("post_rst_cmd_ready", cmd_ready_o, 1'b1);

        // write, completer ready on the first access cycle
        clr_obs();
        pready = 1'b1;
        prdata = 32'hDEAD_BEEF;
        send(1'b1, 12'h008, 32'hA5A5_0001, 4'hF);
        wait_rsp(40);
        chk("wr_latency",      obs_lat,      3);
        chk("wr_psel_cycles",  obs_psel,     2);
        chk("wr_pen_cycles",   obs_pen,      1);
        chk("wr_slverr",       rsp_slverr_o, 1'b0);
        chk("wr_rdata",        rsp_rdata_o,  32'h0);
        chk("model_wr_access", m_last_acc,   1);
        consume();

        // read with three wait states
        clr_obs();
        pready = 1'b0;
        send(1'b0, 12'h004, 32'h1234_5678, 4'hF);
        repeat (4) tick();
        pready = 1'b1;
        prdata = 32'h0000_00C3;
        wait_rsp(40);
        pready = 1'b0;
        chk("rd_pen_cycles",   obs_pen,     4);
        chk("rd_psel_cycles",  obs_psel,    5);
        chk("rd_latency",      obs_lat,     6);
        chk("rd_rdata",        rsp_rdata_o, 32'h0000_00C3);
        chk("rd_pstrb_zero",   obs_strb_or, 4'h0);
        chk("rd_pwdata_zero",  obs_wd_or,   32'h0);
        chk("model_rd_access", m_last_acc,  4);
        consume();

        // illegal: above range, then unaligned; bus must stay idle
        pready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            clr_obs();
            send(k[0], (k == 0) ? 12'h014 : 12'h002, 32'hFFFF_FFFF, 4'hF);
            wait_rsp(10);
            chk("ill_latency", obs_lat,       1);
            chk("ill_psel",    obs_psel,      0);
            chk("ill_slverr",  rsp_slverr_o,  1'b1);
            chk("ill_timeout", rsp_timeout_o, 1'b0);
            chk("ill_rdata",   rsp_rdata_o,   32'h0);
            consume();
        end

        // timeout with pready held low
        clr_obs();
        pready = 1'b0;
        prdata = 32'h7777_7777;
        send(1'b0, 12'h00C, 32'h0, 4'h0);
        wait_rsp(60);
        chk("to_pen_cycles", obs_pen,       16);
        chk("to_latency",    obs_lat,       18);
        chk("to_slverr",     rsp_slverr_o,  1'b1);
        chk("to_timeout",    rsp_timeout_o, 1'b1);
        chk("to_rdata",      rsp_rdata_o,   32'h0);
        chk("model_to_acc",  m_last_acc,    16);
        consume();

        // pready on the 16th access cycle is a normal completion; ADDR_MAX is legal
        clr_obs();
        send(1'b0, 12'h010, 32'h0, 4'h0);
        repeat (16) tick();
        pready = 1'b1;
        prdata = 32'h5A5A_1234;
        wait_rsp(10);
        pready = 1'b0;
        chk("edge_pen_cycles", obs_pen,       16);
        chk("edge_timeout",    rsp_timeout_o, 1'b0);
        chk("edge_slverr",     rsp_slverr_o,  1'b0);
        chk("edge_rdata",      rsp_rdata_o,   32'h5A5A_1234);
        consume();

        // response backpressure with a completer error; new command offered meanwhile
        pready = 1'b1;
        pslverr = 1'b1;
        prdata = 32'h0BAD_F00D;
        send(1'b0, 12'h00C, 32'h0, 4'h0);
        wait_rsp(10);
        pslverr = 1'b0;
        prdata = 32'h1111_1111;
        cmd_valid_i = 1'b1;
        cmd_addr_i = 12'h000;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_cmd_ready", cmd_ready_o,  1'b0);
            chk("bp_rsp_valid", rsp_valid_o,  1'b1);
            chk("bp_rdata",     rsp_rdata_o,  32'h0BAD_F00D);
            chk("bp_slverr",    rsp_slverr_o, 1'b1);
        end
        cmd_valid_i = 1'b0;
        consume();
        pready = 1'b0;

        // reset during ACCESS aborts the transfer without a response
        send(1'b0, 12'h000, 32'h0, 4'h0);
        tick();
        tick();
        chk("ra_in_access", penable, 1'b1);
        preset = 1'b1;
        tick();
        chk("ra_psel",      psel,        1'b0);
        chk("ra_penable",   penable,     1'b0);
        chk("ra_cmd_ready", cmd_ready_o, 1'b0);
        clr_obs();
        preset = 1'b0;
        pready = 1'b1;
        tick();
        chk("ra_cmd_ready_after", cmd_ready_o, 1'b1);
        repeat (4) tick();
        chk("ra_no_rsp", obs_rsp, 0);

        // random traffic, checked every cycle by the compare process
        thr = 5;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                case ($urandom_range(0, 3))
                    0: thr = 0;
                    1: thr = 3;
                    2: thr = 7;
                    default: thr = 10;
                endcase
            end
            preset      = ($urandom_range(0, 299) == 0);
            cmd_valid_i = $urandom_range(0, 1) != 0;
            cmd_write_i = $urandom_range(0, 1) != 0;
            case ($urandom_range(0, 7))
                0, 1, 2, 3, 4: cmd_addr_i = 12'($urandom_range(0, 4) * 4);
                5:             cmd_addr_i = 12'($urandom_range(17, 4095));
                6:             cmd_addr_i = 12'($urandom_range(0, 4) * 4 + $urandom_range(1, 3));
                default:       cmd_addr_i = 12'($urandom);
            endcase
            cmd_wdata_i = $urandom;
            cmd_strb_i  = 4'($urandom);
            prdata      = $urandom;
            pslverr     = $urandom_range(0, 3) == 0;
            pready      = $urandom_range(0, 9) < thr;
            rsp_ready_i = $urandom_range(0, 2) != 0;
            tick();
        end

        preset = 1'b0;
        cmd_valid_i = 1'b0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_MIN, default 12'h000: lowest legal target byte address.
REQ-002 Parameter ADDR_MAX, default 12'h010: highest legal target byte address.
REQ-003 Parameter TIMEOUT_CYCLES, default 16: maximum ACCESS cycles allowed before the transfer is aborted.
REQ-004 pclk  input  1  sole clock; all state updates on rising edge.
REQ-005 preset  input  1  reset, synchronous, active-high.
REQ-006 cmd_valid_i / cmd_ready_o  input/output  1/1  command handshake; accepted on the edge where both are 1.
REQ-007 cmd_write_i  input  1  1 = write, 0 = read.
REQ-008 cmd_addr_i  input  12  byte address.
REQ-009 cmd_wdata_i / cmd_strb_i  input  32/4  write data and byte strobes.
REQ-010 rsp_valid_o / rsp_ready_i  output/input  1/1  response handshake; consumed on the edge where both are 1.
REQ-011 rsp_rdata_o / rsp_slverr_o / rsp_timeout_o  output  32/1/1  read data, error flag, timeout flag.
REQ-012 psel, penable, pwrite  output  1 each  APB control.
REQ-013 paddr / pwdata / pstrb  output  12/32/4  APB address, write data, strobes.
REQ-014 prdata / pready / pslverr  input  32/1/1  APB completer return signals.

Function
REQ-015 FSM states: IDLE, SETUP, ACCESS, RESP.
REQ-016 cmd_ready_o = 1 only in IDLE with preset low.
REQ-017 On acceptance, latch write, addr, wdata and strb into a one-entry command register.
REQ-018 IDLE -> SETUP on acceptance of a legal command; legal = ADDR_MIN <= addr <= ADDR_MAX and addr[1:0] == 2'b00.
REQ-019 IDLE -> RESP on acceptance of an illegal command, with no APB activity: rsp_slverr_o=1, rsp_timeout_o=0, rsp_rdata_o=0.
REQ-020 SETUP: psel=1, penable=0; paddr, pwrite, pwdata and pstrb driven from the command register; always lasts exactly one cycle, then ACCESS.
REQ-021 ACCESS: psel=1, penable=1; paddr, pwrite, pwdata and pstrb held stable.
REQ-022 In ACCESS, the edge with pready=1 captures rsp_rdata_o = prdata for reads (0 for writes) and rsp_slverr_o = pslverr, then goes to RESP.
REQ-023 For reads, pstrb SHALL be 4'b0000 and pwdata 0.
REQ-024 Wait counter: cleared on entering ACCESS; increments each ACCESS cycle with pready=0.
REQ-025 Counter saturation: when the counter reaches TIMEOUT_CYCLES with pready still 0, go to RESP with rsp_slverr_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
REQ-026 Counter width: $clog2(TIMEOUT_CYCLES+1).
REQ-027 Timeout vs. pready: pready=1 in the same cycle as counter saturation counts as normal completion, not timeout.
REQ-028 RESP: rsp_valid_o=1; psel=0, penable=0; response fields held stable until rsp_ready_i=1, then IDLE.
REQ-029 RESP is a register stage: minimum accept-to-rsp_valid_o latency is 3 cycles (SETUP, ACCESS, RESP).
REQ-030 No new command is accepted while a response is pending; at most one transfer is outstanding.
REQ-031 Outside SETUP/ACCESS, paddr, pwdata, pstrb and pwrite SHALL be 0.
REQ-032 rsp_ready_i asserted outside RESP has no effect.
REQ-033 pready, prdata and pslverr are ignored outside ACCESS.

Reset
REQ-034 At any edge with preset=1: FSM -> IDLE; counter and command register cleared.
REQ-035 While preset=1, all outputs SHALL be 0, including cmd_ready_o and rsp_valid_o.
REQ-036 Reset in SETUP/ACCESS aborts the transfer: psel and penable are 0 from the next cycle, and no response is produced.

Verification
REQ-037 Write: cmd addr=0x008, wdata=0xA5A5_0001, strb=4'hF; pready=1 on first ACCESS cycle -> psel high 2 cycles, penable high 1 cycle; rsp_valid_o 3 cycles after accept; slverr=0.
REQ-038 Read with waits: addr=0x004; pready low 3 ACCESS cycles, then 1 with prdata=0x0000_00C3 -> ACCESS lasts 4 cycles; rsp_rdata_o=0x0000_00C3; pstrb=0 throughout.
REQ-039 Illegal: addr=0x014 (> ADDR_MAX), then addr=0x002 (unaligned) -> psel never asserted; rsp_slverr_o=1 one cycle after each accept.
REQ-040 Timeout: pready held 0 -> exactly 16 ACCESS wait cycles, then rsp_slverr_o=1 and rsp_timeout_o=1.
REQ-041 Backpressure: rsp_ready_i=0 for 5 cycles -> rsp fields stable, cmd_ready_o=0 throughout; pslverr=1 from completer propagates to rsp_slverr_o.
REQ-042 Reset in ACCESS -> psel=0 and cmd_ready_o=0 next cycle; cmd_ready_o=1 the first cycle after preset drops; no rsp_valid_o.
